// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes R/LD/SD/BEQ requests (i_kind,i_rd,i_rs1,i_rs2,i_funct3,i_funct7,i_imm via i_in_valid/o_in_ready) and writes them to imem (o_mem_we/o_mem_addr/o_mem_wdata) per i_start/i_finish session with o_count/o_full/o_done
module instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_finish,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_kind,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [11:0]       i_imm,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [CW-1:0]     o_count,
  output logic              o_full,
  output logic              o_done
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       w_word;
  logic              w_accept;
  assign o_in_ready = r_state == LOAD;
  assign w_accept = i_in_valid && o_in_ready;
  always_comb begin
    w_word = i_kind == 2'b00 ? {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, 7'b0110011} :
             i_kind == 2'b01 ? {i_imm, i_rs1, 3'b011, i_rd, 7'b0000011} :
             i_kind == 2'b10 ? {i_imm[11:5], i_rs2, i_rs1, 3'b011, i_imm[4:0], 7'b0100011} :
                               {i_imm[11], i_imm[9:4], i_rs2, i_rs1, 3'b000, i_imm[3:0], i_imm[10], 7'b1100111};
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_base <= '0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_count <= '0;
      o_full <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_mem_we <= w_accept;
      if (w_accept) begin
        o_mem_wdata <= w_word;
        o_mem_addr <= r_base + (ADDR_W'(o_count) << 2);
      end
      if (i_start) begin
        r_state <= LOAD;
        r_base <= i_base_addr & ~ADDR_W'(3);
        o_count <= '0;
        o_full <= 1'b0;
        o_done <= 1'b0;
      end else if (r_state == LOAD || r_state == FULL) begin
        if (w_accept) begin
          o_count <= o_count + CW'(1);
          if (o_count == CW'(DEPTH - 1)) begin
            o_full <= 1'b1;
            r_state <= FULL;
          end
        end
        if (i_finish) begin
          r_state <= DONE;
          o_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Program-load block that is the encode side of the main control decoder's opcode interface. It accepts symbolic instruction requests (kind, registers, funct, immediate) over a valid/ready handshake. Each request is packed into a 32-bit instruction word using the codebase opcode set (R_Type 0110011, LD 0000011, SD 0100011, BEQ 1100111), and the words are written sequentially into instruction memory. Testbenches and the boot path use it to fill instruction memory before the datapath runs.

Parameters:
ADDR_W, 32, instruction memory byte-address width
DEPTH, 64, maximum words loaded per session (>=1)

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; opens a session at base_addr
base_addr  input  ADDR_W  byte address of the first word; bits [1:0] ignored and treated as 0
finish  input  1  one-cycle pulse; closes the session
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
kind  input  2  00 R_Type, 01 LD, 10 SD, 11 BEQ
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  used by R_Type only
funct7  input  7  used by R_Type only
imm  input  12  LD/SD: imm[11:0]; BEQ: branch offset bits [12:1]
mem_we  output  1  instruction memory write strobe
mem_addr  output  ADDR_W  write byte address
mem_wdata  output  32  encoded instruction word
count  output  7  words written this session (width ceil(log2(DEPTH+1)), 7 at default)
full  output  1  count == DEPTH
done  output  1  session closed; held until the next start or reset

Behaviour:
- Reset (async, active-high) forces: state IDLE; in_ready, mem_we, full and done = 0; mem_addr, mem_wdata and count = 0. Reset mid-session abandons the session. No write is issued for a request that was accepted but not yet written.
- FSM states: IDLE, LOAD, FULL, DONE.
- IDLE: in_ready = 0.
  - start: latch base (low 2 bits zeroed), count <= 0, done <= 0, go to LOAD.
- LOAD: in_ready = 1. A transfer occurs when in_valid && in_ready.
  - Each transfer is encoded and registered. In the next cycle mem_we = 1 (for exactly one cycle), mem_wdata = encoded word, mem_addr = base + 4*count. count increments in that same write cycle.
  - Latency: 1 cycle from accept to write. Back-to-back accepts give back-to-back writes at consecutive addresses.
  - Address arithmetic is modulo 2^ADDR_W; wrap-around is allowed and not flagged.
- Encodings (codebase opcodes; LD/SD funct3 = 011, BEQ funct3 = 000):
  - R_Type: {funct7, rs2, rs1, funct3, rd, 0110011}
  - LD: {imm[11:0], rs1, 011, rd, 0000011}; rs2 ignored
  - SD: {imm[11:5], rs2, rs1, 011, imm[4:0], 0100011}; rd ignored
  - BEQ: with offset o = {imm, 1'b0}: {o[12], o[10:5], rs2, rs1, 000, o[4:1], o[11], 1100111}; rd ignored
  - funct3/funct7 are ignored for non-R kinds.
- Full:
  - in_ready drops combinationally when the accept that would make count == DEPTH has been taken. No request is accepted while (count + pending write) == DEPTH.
  - After the DEPTH-th write, go to FULL: full = 1, in_ready = 0.
- finish in LOAD or FULL: any pending write still completes. Then go to DONE: done = 1, in_ready = 0, count and full hold their values.
- finish with an accepted in_valid in the same cycle: that request is written, then DONE.
- start in LOAD, FULL or DONE: restarts the session (count <= 0, full <= 0, done <= 0, new base). Any pending write still completes at its old address in that cycle, but it is not counted.
- start and finish in the same cycle: start wins.
- finish in IDLE: ignored.

Test Plan:
- Reset then start, base_addr=0x100, R_Type with funct7=0, rs2=2, rs1=1, funct3=0, rd=3 -> one cycle later mem_we=1, mem_addr=0x100, mem_wdata=0x002081B3, count=1.
- Back-to-back LD rd=5, rs1=2, imm=8 then SD rs2=6, rs1=2, imm=16 -> writes 0x00813283 @0x100 and 0x00613823 @0x104 on consecutive cycles.
- BEQ rs1=1, rs2=2, imm=12'hFFC (offset -8) -> mem_wdata=0xFE208CE7.
- DEPTH=4, hold in_valid high -> exactly 4 writes (0x100..0x10C), full=1, in_ready=0, fifth request never accepted; then finish -> done=1, count=4.
- finish asserted together with an accepted R_Type -> that word is written, then done=1 and in_ready=0. Later start with base_addr=0x203 -> first write goes to 0x200, count restarts at 1.
- Assert reset in the cycle after an accept -> no mem_we pulse; all outputs 0; state IDLE.
